// File: rtl/sequence_serializer.sv
// Byte serializer: queues 1-4 byte sequence pulses in a small FIFO and streams them out
// most-significant byte first over a valid/ready handshake, counting sequences dropped on overflow.
module sequence_serializer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                sequence_in,
   input  logic [2:0]                 sequence_in_count,
   output logic [7:0]                 byte_out,
   output logic                       byte_valid,
   input  logic                       byte_ready,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow,
   output logic [7:0]                 overflow_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   // Each entry holds {byte count, packed sequence}.
   logic [34:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;

   state_e        state_q, state_d;
   logic [31:0]   shift_q, shift_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          overflow_q;
   logic [7:0]    ovf_cnt_q;

   logic          req, full, empty, push, drop, pop, xfer;
   logic [2:0]    req_len;
   logic [34:0]   rd_entry;
   logic [2:0]    rd_len;
   logic [31:0]   load_shift;

   always_comb begin
      req     = |sequence_in_count;
      req_len = (sequence_in_count > 3'd4) ? 3'd4 : sequence_in_count;
      // Fullness is taken before any same-edge pop, so a full FIFO always drops.
      full    = (level_q == LW'(DEPTH));
      empty   = (level_q == '0);
      push    = req & ~full;
      drop    = req & full;
      xfer    = byte_valid & byte_ready;
   end

   always_comb begin
      rd_entry   = mem_q[rd_ptr_q];
      rd_len     = rd_entry[34:32];
      load_shift = rd_entry[31:0] << {(3'd4 - rd_len), 3'b000};
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = load_shift;
               cnt_d   = rd_len;
               state_d = StSend;
            end
         end
         StSend: begin
            if (xfer) begin
               if (cnt_q > 3'd1) begin
                  shift_d = {shift_q[23:0], 8'h00};
                  cnt_d   = cnt_q - 3'd1;
               end else if (!empty) begin
                  // Chain straight into the next sequence with no bubble.
                  pop     = 1'b1;
                  shift_d = load_shift;
                  cnt_d   = rd_len;
               end else begin
                  shift_d = '0;
                  cnt_d   = '0;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {req_len, sequence_in};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         state_q    <= StIdle;
         shift_q    <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         ovf_cnt_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q    <= level_d;
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         overflow_q <= drop;
         if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
   end

   always_comb begin
      byte_valid     = (state_q == StSend);
      byte_out       = shift_q[31:24];
      busy           = byte_valid | ~empty;
      fifo_level     = level_q;
      overflow       = overflow_q;
      overflow_count = ovf_cnt_q;
   end

endmodule

// File: tb/tb_sequence_serializer.sv
// Directed self-checking bench for sequence_serializer (DEPTH=4).
module tb_sequence_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] sequence_in;
   logic [2:0]  sequence_in_count;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        busy;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic [7:0]  overflow_count;

   int checks = 0;
   int errors = 0;

   sequence_serializer #(.DEPTH(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .sequence_in       (sequence_in),
      .sequence_in_count (sequence_in_count),
      .byte_out          (byte_out),
      .byte_valid        (byte_valid),
      .byte_ready        (byte_ready),
      .busy              (busy),
      .fifo_level        (fifo_level),
      .overflow          (overflow),
      .overflow_count    (overflow_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset             = 1'b0;
      sequence_in       = '0;
      sequence_in_count = '0;
      byte_ready        = 1'b0;
      #2;
      chk("rst_valid", 32'(byte_valid), 32'd0);
      chk("rst_out", 32'(byte_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_ovfcnt", 32'(overflow_count), 32'd0);
      tick();
      tick();
      reset = 1'b1;

      // Single 4-byte sequence
      byte_ready        = 1'b1;
      sequence_in       = 32'h1E81A007;
      sequence_in_count = 3'd4;
      tick();
      sequence_in_count = 3'd0;
      chk("t1_e0_valid", 32'(byte_valid), 32'd0);
      chk("t1_e0_level", 32'(fifo_level), 32'd1);
      chk("t1_e0_busy", 32'(busy), 32'd1);
      tick();
      chk("t1_b0_valid", 32'(byte_valid), 32'd1);
      chk("t1_b0", 32'(byte_out), 32'h1E);
      chk("t1_b0_level", 32'(fifo_level), 32'd0);
      tick();
      chk("t1_b1", 32'(byte_out), 32'h81);
      tick();
      chk("t1_b2", 32'(byte_out), 32'hA0);
      tick();
      chk("t1_b3", 32'(byte_out), 32'h07);
      chk("t1_b3_valid", 32'(byte_valid), 32'd1);
      tick();
      chk("t1_end_valid", 32'(byte_valid), 32'd0);
      chk("t1_end_busy", 32'(busy), 32'd0);

      // Short sequences back-to-back
      sequence_in       = 32'h00000041;
      sequence_in_count = 3'd1;
      tick();
      sequence_in       = 32'h00001B5B;
      sequence_in_count = 3'd2;
      tick();
      sequence_in_count = 3'd0;
      chk("t2_b0", 32'(byte_out), 32'h41);
      chk("t2_b0_valid", 32'(byte_valid), 32'd1);
      chk("t2_b0_level", 32'(fifo_level), 32'd1);
      tick();
      chk("t2_b1", 32'(byte_out), 32'h1B);
      chk("t2_b1_valid", 32'(byte_valid), 32'd1);
      chk("t2_b1_level", 32'(fifo_level), 32'd0);
      tick();
      chk("t2_b2", 32'(byte_out), 32'h5B);
      tick();
      chk("t2_end_valid", 32'(byte_valid), 32'd0);
      chk("t2_end_busy", 32'(busy), 32'd0);

      // Backpressure mid-sequence
      sequence_in       = 32'h11223344;
      sequence_in_count = 3'd4;
      tick();
      sequence_in_count = 3'd0;
      tick();
      chk("t3_b0", 32'(byte_out), 32'h11);
      tick();
      chk("t3_b1", 32'(byte_out), 32'h22);
      byte_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_hold_out", 32'(byte_out), 32'h22);
         chk("t3_hold_valid", 32'(byte_valid), 32'd1);
      end
      byte_ready = 1'b1;
      tick();
      chk("t3_b2", 32'(byte_out), 32'h33);
      tick();
      chk("t3_b3", 32'(byte_out), 32'h44);
      tick();
      chk("t3_end_valid", 32'(byte_valid), 32'd0);

      // Overflow with DEPTH=4
      byte_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sequence_in       = 32'hA1 + 32'(i);
         sequence_in_count = 3'd1;
         tick();
         chk("t4_ovf_pulse", 32'(overflow), (i == 5) ? 32'd1 : 32'd0);
      end
      sequence_in_count = 3'd0;
      chk("t4_level", 32'(fifo_level), 32'd4);
      chk("t4_ovfcnt", 32'(overflow_count), 32'd1);
      chk("t4_head", 32'(byte_out), 32'hA1);
      tick();
      chk("t4_ovf_drop", 32'(overflow), 32'd0);
      chk("t4_ovfcnt_hold", 32'(overflow_count), 32'd1);
      byte_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("t4_drain_out", 32'(byte_out), 32'hA1 + 32'(k));
         chk("t4_drain_valid", 32'(byte_valid), 32'd1);
         tick();
      end
      chk("t4_end_valid", 32'(byte_valid), 32'd0);
      chk("t4_end_level", 32'(fifo_level), 32'd0);
      chk("t4_end_busy", 32'(busy), 32'd0);

      // Count 7 treated as 4; count 0 captures nothing
      sequence_in       = 32'hAABBCCDD;
      sequence_in_count = 3'd7;
      tick();
      sequence_in       = 32'hDEADBEEF;
      sequence_in_count = 3'd0;
      tick();
      chk("t5_b0", 32'(byte_out), 32'hAA);
      chk("t5_level", 32'(fifo_level), 32'd0);
      tick();
      chk("t5_b1", 32'(byte_out), 32'hBB);
      tick();
      chk("t5_b2", 32'(byte_out), 32'hCC);
      tick();
      chk("t5_b3", 32'(byte_out), 32'hDD);
      tick();
      chk("t5_end_valid", 32'(byte_valid), 32'd0);
      tick();
      chk("t5_n0_valid", 32'(byte_valid), 32'd0);
      chk("t5_n0_level", 32'(fifo_level), 32'd0);

      // Reset mid-sequence with two queued sequences
      sequence_in       = 32'h01020304;
      sequence_in_count = 3'd4;
      tick();
      sequence_in       = 32'h00000055;
      sequence_in_count = 3'd1;
      tick();
      chk("t6_b0", 32'(byte_out), 32'h01);
      sequence_in       = 32'h00000066;
      tick();
      sequence_in_count = 3'd0;
      chk("t6_b1", 32'(byte_out), 32'h02);
      tick();
      chk("t6_b2", 32'(byte_out), 32'h03);
      chk("t6_level", 32'(fifo_level), 32'd2);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(byte_valid), 32'd0);
      chk("t6_rst_level", 32'(fifo_level), 32'd0);
      chk("t6_rst_ovfcnt", 32'(overflow_count), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      tick();
      reset             = 1'b1;
      sequence_in       = 32'h00000099;
      sequence_in_count = 3'd1;
      tick();
      sequence_in_count = 3'd0;
      chk("t6_new_e0_valid", 32'(byte_valid), 32'd0);
      chk("t6_new_e0_level", 32'(fifo_level), 32'd1);
      tick();
      chk("t6_new_valid", 32'(byte_valid), 32'd1);
      chk("t6_new_out", 32'(byte_out), 32'h99);
      tick();
      chk("t6_new_end", 32'(byte_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sequence_serializer.md
# sequence_serializer

Byte serializer downstream of the mouse/keyboard sequence encoders. Captures one-cycle multi-byte sequence pulses (`sequence_out`/`sequence_out_count` style, 1–4 bytes packed in 32 bits) into a small sequence FIFO. Emits them one byte at a time, most significant first, over a valid/ready handshake to the serial transmitter. Absorbs bursts while the transmitter is busy and reports sequences dropped on overflow.

## Interface
- `DEPTH`, 4: sequence FIFO depth in whole sequences; power of two, ≥2.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `sequence_in`  in  32  packed sequence; N valid bytes right-aligned, first byte in [8N-1:8N-8], last in [7:0].
- `sequence_in_count`  in  3  byte count N, sampled every cycle; 0 = no request; 5–7 treated as 4.
- `byte_out`  out  8  current byte to transmit.
- `byte_valid`  out  1  `byte_out` holds a byte to transfer.
- `byte_ready`  in  1  transmitter accepts; transfer = `byte_valid & byte_ready` at a rising edge.
- `busy`  out  1  `byte_valid` or FIFO non-empty.
- `fifo_level`  out  $clog2(DEPTH)+1  sequences stored, excluding the one being sent.
- `overflow`  out  1  one-cycle pulse when a sequence is dropped.
- `overflow_count`  out  8  sequences dropped since reset, saturates at 255.

## Operation
- Reset (`reset`=0, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, shift register 0. Reset mid-transfer abandons the current byte and all queued sequences.
- Capture: every edge with N≠0:
  - FIFO not full → write {N, `sequence_in`}.
  - FIFO full → drop the whole sequence, pulse `overflow`, increment `overflow_count` (saturating).
  - Fullness is evaluated before any same-edge pop. A full FIFO drops even if the FSM pops on that edge.
- Load: the popped entry is left-aligned into a 32-bit shift register (shifted left by 8·(4−N)). A byte counter is set to N.
- FSM:
  - IDLE: `byte_valid`=0. FIFO non-empty → pop, load, go SEND.
  - SEND: `byte_valid`=1, `byte_out` = shift[31:24]. On transfer: shift left 8, counter −1.
    - Counter was >1 → stay in SEND.
    - Counter was 1 and FIFO non-empty → pop and load on the same edge, stay in SEND.
    - Counter was 1 and FIFO empty → go IDLE.
  - Without a transfer, `byte_out` and `byte_valid` hold stable. `byte_valid` never drops before a transfer.
- Simultaneous push and pop on a non-full FIFO: both occur, and `fifo_level` is unchanged.
- Byte order within a sequence is preserved. Sequence order is FIFO order.

## Timing
- Empty and idle, sequence captured at edge E0: FSM pops at E1, `byte_valid`=1 and first byte on `byte_out` from E1. Latency is 2 edges.
- With `byte_ready` held 1, an N-byte sequence occupies exactly N consecutive cycles of `byte_valid`.
- Queued sequences follow with zero bubble cycles.
- `overflow` is high for the single cycle following the dropping edge.
- `busy` falls on the same edge `byte_valid` falls with an empty FIFO.
- `fifo_level` updates on the capture/pop edge. Max value is DEPTH.

## Test plan
- Single 4-byte sequence: `sequence_in`=0x1E81A007, N=4, `byte_ready`=1.
  - Required: `byte_valid` from E1 for 4 cycles; bytes 0x1E, 0x81, 0xA0, 0x07; then IDLE, `busy`=0.
- Short sequences: N=1 with 0x000000_41, then N=2 with 0x0000_1B5B.
  - Required: bytes 0x41, 0x1B, 0x5B, back-to-back with no gap between the sequences.
- Backpressure: `byte_ready`=0 for 5 cycles mid-sequence.
  - Required: `byte_out` and `byte_valid` stable throughout; no byte lost or duplicated.
- Overflow, DEPTH=4: `byte_ready`=0, push 6 one-cycle sequences.
  - First is loaded into SEND. Next 4 fill the FIFO (`fifo_level`=4). Sixth is dropped.
  - Required: `overflow` pulses once, `overflow_count`=1. Releasing `byte_ready` outputs the 5 kept sequences in order.
- Count 7 with 0xAABBCCDD → treated as 4: bytes 0xAA, 0xBB, 0xCC, 0xDD. Count 0 for any data → nothing captured.
- Reset mid-sequence after byte 2 of 4, with 2 sequences queued.
  - Required: immediate `byte_valid`=0, `fifo_level`=0, `overflow_count`=0.
  - After release, a new sequence transmits normally with latency 2.
